id_scoreboard: RTL and testbench

Parametrised register scoreboard and operand-forwarding unit for the decode stage. It tracks in-flight register writes with per-register latency countdowns, so producers with any result latency (loads, multi-cycle mul/div) can stall dependent instructions. It replaces the fixed one-cycle load-use check. It also muxes forwarded operands (EX > MEM > WB > regfile) for NRP read ports. It sits inside ID, between the regfile read ports and the ID→EX bus, and drives ID's stallreq.

---
 rtl/id_pkg.sv | 33 +++
 rtl/sb_entry.sv | 34 +++
 rtl/id_scoreboard.sv | 111 +++++++++++
 tb/tb_id_scoreboard.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode-stage definitions: GPR geometry, forwarding-source priority
// and the standard producer latencies used when issuing into EX.
package id_pkg;

    localparam int NUM_GPR = 32;
    localparam int GPR_AW  = 5;

    typedef logic [GPR_AW-1:0] gpr_addr_t;

    // Forwarding sources, listed from highest to lowest priority.
    typedef enum logic [1:0] {
        FWD_EX  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2,
        FWD_RF  = 2'd3
    } fwd_src_e;

    // Cycles until a producer's result reaches a forwarding bus.
    localparam int LAT_ALU    = 0;
    localparam int LAT_LOAD   = 1;
    localparam int LAT_MULDIV = 4;

    // Youngest matching producer wins: EX, then MEM, then WB, else regfile.
    function automatic fwd_src_e fwd_select(input logic ex_hit,
                                            input logic mem_hit,
                                            input logic wb_hit);
        if (ex_hit)       return FWD_EX;
        else if (mem_hit) return FWD_MEM;
        else if (wb_hit)  return FWD_WB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: busy bit plus latency countdown for a single GPR.
// Priority at each edge: reset > issue > (retire, decrement).
module sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             retire,
    output logic             busy,
    output logic [LAT_W-1:0] cnt
);

    // Issue reloads the entry even when a retire of the same register lands
    // on the same edge; otherwise retire clears busy and cnt counts down to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (issue) begin
            busy <= 1'b1;
            cnt  <= issue_lat;
        end else begin
            if (retire) begin
                busy <= 1'b0;
            end
            if (cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// Register scoreboard and operand-forwarding unit for the decode stage.
//
// Handshake: issue_valid is the only transfer qualifier. When it is high the
// instruction leaves ID this cycle and its destination is recorded at the next
// edge. stallreq is advisory to the pipeline control: while it is high the
// surrounding logic must hold ID and drive issue_valid low; this block never
// gates issue on its own stallreq.
//
// Optional feature: define ID_SB_WAW_STALL_EN to also stall an issuing write
// whose latency is shorter than the remaining countdown of an older write to
// the same register. Without it the older entry is simply overwritten.
module id_scoreboard
    import id_pkg::*;
#(
    parameter int NRP   = 2,
    parameter int DW    = 32,
    parameter int LAT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_we,
    input  logic [GPR_AW-1:0]     issue_rd,
    input  logic [LAT_W-1:0]      issue_lat,
    input  logic [NRP-1:0]        rd_valid,
    input  logic [NRP*GPR_AW-1:0] rd_addr,
    input  logic [NRP*DW-1:0]     rf_rdata,
    input  logic                  ex_we,
    input  logic [GPR_AW-1:0]     ex_waddr,
    input  logic [DW-1:0]         ex_wdata,
    input  logic                  mem_we,
    input  logic [GPR_AW-1:0]     mem_waddr,
    input  logic [DW-1:0]         mem_wdata,
    input  logic                  wb_we,
    input  logic [GPR_AW-1:0]     wb_waddr,
    input  logic [DW-1:0]         wb_wdata,
    output logic [NRP*DW-1:0]     op_rdata,
    output logic                  stallreq,
    output logic [NUM_GPR-1:0]    sb_busy
);

    logic [LAT_W-1:0] cnt [NUM_GPR];
    logic [NRP-1:0]   port_stall;
    logic             waw_stall;

    // r0 is hardwired zero and therefore never has an in-flight write.
    assign sb_busy[0] = 1'b0;
    assign cnt[0]     = '0;

    for (genvar r = 1; r < NUM_GPR; r++) begin : g_entry
        logic hit_issue;
        logic hit_retire;

        assign hit_issue  = issue_valid && issue_we && (issue_rd == GPR_AW'(r));
        assign hit_retire = wb_we && (wb_waddr == GPR_AW'(r));

        sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .issue     (hit_issue),
            .issue_lat (issue_lat),
            .retire    (hit_retire),
            .busy      (sb_busy[r]),
            .cnt       (cnt[r])
        );
    end

    for (genvar i = 0; i < NRP; i++) begin : g_port
        logic [GPR_AW-1:0] addr;
        logic              ex_hit;
        logic              mem_hit;
        logic              wb_hit;

        assign addr    = rd_addr[GPR_AW*i +: GPR_AW];
        assign ex_hit  = ex_we  && (ex_waddr  == addr);
        assign mem_hit = mem_we && (mem_waddr == addr);
        assign wb_hit  = wb_we  && (wb_waddr  == addr);

        // A read stalls only while its producer's result is not yet on a bus.
        assign port_stall[i] = rd_valid[i] && (addr != '0) &&
                               sb_busy[addr] && (cnt[addr] != '0);

        // Forwarding mux; scoreboard state deliberately does not gate it.
        always_comb begin
            op_rdata[DW*i +: DW] = rf_rdata[DW*i +: DW];
            if (addr == '0) begin
                op_rdata[DW*i +: DW] = '0;
            end else begin
                case (fwd_select(ex_hit, mem_hit, wb_hit))
                    FWD_EX:  op_rdata[DW*i +: DW] = ex_wdata;
                    FWD_MEM: op_rdata[DW*i +: DW] = mem_wdata;
                    FWD_WB:  op_rdata[DW*i +: DW] = wb_wdata;
                    default: op_rdata[DW*i +: DW] = rf_rdata[DW*i +: DW];
                endcase
            end
        end
    end

`ifdef ID_SB_WAW_STALL_EN
    // Hold a short-latency write that would overtake an older, slower one.
    assign waw_stall = issue_valid && issue_we && (issue_rd != '0) &&
                       sb_busy[issue_rd] && (cnt[issue_rd] > issue_lat);
`else
    assign waw_stall = 1'b0;
`endif

    assign stallreq = (|port_stall) || waw_stall;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard.
module tb_id_scoreboard;

    localparam int NRP   = 2;
    localparam int DW    = 32;
    localparam int LAT_W = 3;

    logic              clk;
    logic              rst;
    logic              issue_valid;
    logic              issue_we;
    logic [4:0]        issue_rd;
    logic [LAT_W-1:0]  issue_lat;
    logic [NRP-1:0]    rd_valid;
    logic [NRP*5-1:0]  rd_addr;
    logic [NRP*DW-1:0] rf_rdata;
    logic              ex_we, mem_we, wb_we;
    logic [4:0]        ex_waddr, mem_waddr, wb_waddr;
    logic [DW-1:0]     ex_wdata, mem_wdata, wb_wdata;
    logic [NRP*DW-1:0] op_rdata;
    logic              stallreq;
    logic [31:0]       sb_busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    id_scoreboard #(
        .NRP   (NRP),
        .DW    (DW),
        .LAT_W (LAT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .issue_lat   (issue_lat),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rf_rdata    (rf_rdata),
        .ex_we       (ex_we),
        .ex_waddr    (ex_waddr),
        .ex_wdata    (ex_wdata),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .op_rdata    (op_rdata),
        .stallreq    (stallreq),
        .sb_busy     (sb_busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push this cycle's expectations, then pop and compare at the falling edge.
    task automatic expect_cycle(input string tag, input logic e_stall,
                                input logic [31:0] e_op0, input logic [31:0] e_op1,
                                input logic [31:0] e_busy);
        logic [31:0] e;
        exp_q.push_back(32'(e_stall));
        exp_q.push_back(e_op0);
        exp_q.push_back(e_op1);
        exp_q.push_back(e_busy);
        @(negedge clk);
        e = exp_q.pop_front(); check({tag, ".stall"}, 32'(stallreq), e);
        e = exp_q.pop_front(); check({tag, ".op0"}, op_rdata[31:0], e);
        e = exp_q.pop_front(); check({tag, ".op1"}, op_rdata[63:32], e);
        e = exp_q.pop_front(); check({tag, ".busy"}, sb_busy, e);
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0; issue_lat = '0;
        rd_valid = '0; rd_addr = '0; rf_rdata = '0;
        ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic set_rd(input int p, input logic v, input logic [4:0] a, input logic [31:0] d);
        rd_valid[p]         = v;
        rd_addr[5*p +: 5]   = a;
        rf_rdata[DW*p +: DW] = d;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd; issue_lat = lat;
    endtask

    task automatic retire(input logic [4:0] rd);
        wb_we = 1'b1; wb_waddr = rd; wb_wdata = 32'hDEAD_0000 | 32'(rd);
    endtask

    // Reference forwarding mux: EX > MEM > WB > regfile, r0 reads zero.
    function automatic logic [31:0] fwd_ref(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0)                   return 32'd0;
        if (ex_we && ex_waddr == a)      return ex_wdata;
        if (mem_we && mem_waddr == a)    return mem_wdata;
        if (wb_we && wb_waddr == a)      return wb_wdata;
        return rf;
    endfunction

    initial begin
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;

        clear_inputs();
        rst = 1'b1;
        next_cycle();
        // Reset dominates a concurrent issue.
        do_issue(5'd2, 3'd3);
        expect_cycle("reset", 1'b0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b0;
        expect_cycle("reset_issue_dropped", 1'b0, 32'h0, 32'h0, 32'h0);

        // Plain regfile read.
        next_cycle();
        set_rd(0, 1'b1, 5'd5, 32'h1234);
        expect_cycle("rf_pass", 1'b0, 32'h1234, 32'h0, 32'h0);

        // Load-use: one stall cycle, then MEM forwarding.
        next_cycle();
        do_issue(5'd3, 3'd1);
        expect_cycle("ld_issue", 1'b0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        set_rd(0, 1'b1, 5'd3, 32'h0BAD);
        expect_cycle("ld_stall", 1'b1, 32'h0BAD, 32'h0, 32'h8);
        next_cycle();
        set_rd(0, 1'b1, 5'd3, 32'h0BAD);
        mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'hCAFE;
        expect_cycle("ld_fwd", 1'b0, 32'hCAFE, 32'h0, 32'h8);
        next_cycle();
        retire(5'd3);
        expect_cycle("ld_retiring", 1'b0, 32'h0, 32'h0, 32'h8);
        next_cycle();
        expect_cycle("ld_retired", 1'b0, 32'h0, 32'h0, 32'h0);

        // Latency 4 on port 1: exactly four stall cycles.
        next_cycle();
        do_issue(5'd8, 3'd4);
        expect_cycle("mul_issue", 1'b0, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            set_rd(1, 1'b1, 5'd8, 32'h800 + 32'(k));
            expect_cycle("mul_stall", 1'b1, 32'h0, 32'h800 + 32'(k), 32'h100);
        end
        next_cycle();
        set_rd(1, 1'b1, 5'd8, 32'h888);
        ex_we = 1'b1; ex_waddr = 5'd8; ex_wdata = 32'hD1D1;
        expect_cycle("mul_release", 1'b0, 32'h0, 32'hD1D1, 32'h100);
        next_cycle();
        retire(5'd8);
        expect_cycle("mul_retiring", 1'b0, 32'h0, 32'h0, 32'h100);

        // Latency 0 never stalls.
        next_cycle();
        do_issue(5'd9, 3'd0);
        expect_cycle("alu_issue", 1'b0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        set_rd(0, 1'b1, 5'd9, 32'h1);
        ex_we = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h99;
        expect_cycle("alu_use", 1'b0, 32'h99, 32'h0, 32'h200);
        next_cycle();
        retire(5'd9);
        expect_cycle("alu_retiring", 1'b0, 32'h0, 32'h0, 32'h200);

        // Forwarding priority.
        next_cycle();
        ex_we = 1'b1;  ex_waddr = 5'd7;  ex_wdata = 32'h1;
        mem_we = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h2;
        wb_we = 1'b1;  wb_waddr = 5'd7;  wb_wdata = 32'h3;
        set_rd(0, 1'b1, 5'd7, 32'h70);
        set_rd(1, 1'b1, 5'd7, 32'h71);
        expect_cycle("fwd_ex", 1'b0, 32'h1, 32'h1, 32'h0);
        next_cycle();
        mem_we = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h2;
        wb_we = 1'b1;  wb_waddr = 5'd7;  wb_wdata = 32'h3;
        set_rd(0, 1'b1, 5'd7, 32'h70);
        expect_cycle("fwd_mem", 1'b0, 32'h2, 32'h0, 32'h0);
        next_cycle();
        wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h3;
        set_rd(1, 1'b1, 5'd7, 32'h71);
        expect_cycle("fwd_wb", 1'b0, 32'h0, 32'h3, 32'h0);
        next_cycle();
        ex_waddr = 5'd7; ex_wdata = 32'h1;
        set_rd(0, 1'b1, 5'd7, 32'h70);
        expect_cycle("fwd_we_low", 1'b0, 32'h70, 32'h0, 32'h0);
        next_cycle();
        ex_we = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'h55;
        set_rd(0, 1'b1, 5'd0, 32'h77);
        set_rd(1, 1'b1, 5'd0, 32'h77);
        expect_cycle("fwd_r0", 1'b0, 32'h0, 32'h0, 32'h0);

        // Issue and retire of $4 on one edge: issue wins and reloads cnt=2.
        next_cycle();
        do_issue(5'd4, 3'd2);
        expect_cycle("reissue_first", 1'b0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        do_issue(5'd4, 3'd2);
        retire(5'd4);
        expect_cycle("reissue_retire", 1'b0, 32'h0, 32'h0, 32'h10);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            set_rd(0, 1'b1, 5'd4, 32'h40);
            expect_cycle("reissue_count", (k < 2), 32'h40, 32'h0, 32'h10);
        end
        next_cycle();
        retire(5'd4);
        expect_cycle("retire4_cycle", 1'b0, 32'h0, 32'h0, 32'h10);
        next_cycle();
        expect_cycle("retire4_done", 1'b0, 32'h0, 32'h0, 32'h0);

        // WAW: $6 busy with cnt=3, then a latency-0 write to $6.
        next_cycle();
        do_issue(5'd6, 3'd3);
        expect_cycle("waw_old", 1'b0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        do_issue(5'd6, 3'd0);
`ifdef ID_SB_WAW_STALL_EN
        expect_cycle("waw_new", 1'b1, 32'h0, 32'h0, 32'h40);
`else
        expect_cycle("waw_new", 1'b0, 32'h0, 32'h0, 32'h40);
`endif
        next_cycle();
        set_rd(0, 1'b1, 5'd6, 32'h60);
        expect_cycle("waw_read", 1'b0, 32'h60, 32'h0, 32'h40);
        next_cycle();
        retire(5'd6);
        expect_cycle("waw_retiring", 1'b0, 32'h0, 32'h0, 32'h40);

        // Reset mid-operation overrides issue and retire.
        next_cycle();
        do_issue(5'd10, 3'd5);
        expect_cycle("mid_issue", 1'b0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b1;
        do_issue(5'd11, 3'd2);
        retire(5'd10);
        set_rd(0, 1'b1, 5'd10, 32'hA0);
        expect_cycle("mid_rst", 1'b1, 32'hDEAD_000A, 32'h0, 32'h400);
        next_cycle();
        rst = 1'b0;
        set_rd(0, 1'b1, 5'd10, 32'hA0);
        set_rd(1, 1'b1, 5'd11, 32'hB0);
        expect_cycle("mid_after", 1'b0, 32'hA0, 32'hB0, 32'h0);

        // Random forwarding patterns with an idle scoreboard.
        for (int n = 0; n < 24; n++) begin
            next_cycle();
            ex_we  = 1'($urandom_range(0, 1)); ex_waddr  = 5'($urandom_range(0, 3)); ex_wdata  = $urandom;
            mem_we = 1'($urandom_range(0, 1)); mem_waddr = 5'($urandom_range(0, 3)); mem_wdata = $urandom;
            wb_we  = 1'($urandom_range(0, 1)); wb_waddr  = 5'($urandom_range(0, 3)); wb_wdata  = $urandom;
            a0 = 5'($urandom_range(0, 3)); d0 = $urandom;
            a1 = 5'($urandom_range(0, 3)); d1 = $urandom;
            set_rd(0, 1'($urandom_range(0, 1)), a0, d0);
            set_rd(1, 1'($urandom_range(0, 1)), a1, d1);
            expect_cycle("rand_fwd", 1'b0, fwd_ref(a0, d0), fwd_ref(a1, d1), 32'h0);
        end

        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
